tlc_phase_ctrl: RTL

Parametrised multi-phase traffic light controller: the next generation of the single-approach red/yellow/green sequencer. It cycles N_PHASES conflicting approaches through green, yellow and all-red clearance. Durations are counted in timebase ticks. It adds latched pedestrian requests with walk outputs and extended green, plus a flashing-yellow maintenance mode. It sits between the intersection timebase divider and the lamp driver outputs.

---
 rtl/tlc_phase_ctrl.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/tlc_phase_ctrl.sv
// Multi-phase traffic light controller.
// Cycles N_PHASES conflicting approaches through green, yellow and all-red
// clearance, serves latched pedestrian requests with a walk lamp and an
// extended green, and offers a flashing-yellow maintenance mode.
// Every lamp output is a registered Moore decode of the next state, so lamps
// change on the same tick edge that moves the state.
module tlc_phase_ctrl #(
    parameter int N_PHASES = 2,
    parameter int CNT_W    = 8,
    parameter int GREEN_T  = 10,
    parameter int YELLOW_T = 3,
    parameter int ALLRED_T = 2,
    parameter int PED_T    = 5,
    localparam int PH_W    = (N_PHASES > 2) ? $clog2(N_PHASES) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                tick,
    input  logic                flash_mode,
    input  logic [N_PHASES-1:0] ped_req,
    output logic [N_PHASES-1:0] r,
    output logic [N_PHASES-1:0] y,
    output logic [N_PHASES-1:0] g,
    output logic [N_PHASES-1:0] walk,
    output logic [PH_W-1:0]     phase
);

    typedef enum logic [2:0] {
        ST_START  = 3'd0,
        ST_ALLRED = 3'd1,
        ST_GREEN  = 3'd2,
        ST_YELLOW = 3'd3,
        ST_FLASH  = 3'd4
    } state_t;

    // Timer reload values: the timer holds "ticks remaining minus one".
    localparam logic [CNT_W-1:0] ALLRED_LD    = CNT_W'(ALLRED_T - 1);
    localparam logic [CNT_W-1:0] GREEN_LD     = CNT_W'(GREEN_T - 1);
    localparam logic [CNT_W-1:0] GREEN_PED_LD = CNT_W'(GREEN_T + PED_T - 1);
    localparam logic [CNT_W-1:0] YELLOW_LD    = CNT_W'(YELLOW_T - 1);
    localparam logic [PH_W-1:0]  LAST_PHASE   = PH_W'(N_PHASES - 1);

    state_t                state_q, state_d;
    logic [PH_W-1:0]       phase_q, phase_d;
    logic [CNT_W-1:0]      timer_q, timer_d;
    logic [N_PHASES-1:0]   pend_q, pend_d, pend_clr;
    logic                  served_q, served_d;
    logic                  toggle_q, toggle_d;
    logic [N_PHASES-1:0]   r_q, r_d, y_q, y_d, g_q, g_d, walk_q, walk_d;
    logic [N_PHASES-1:0]   ph_sel_q, ph_sel_d;
    logic [PH_W-1:0]       phase_inc;
    logic                  phase_legal;

    // One-hot decode of the current and next phase index.
    for (genvar gi = 0; gi < N_PHASES; gi++) begin : g_sel
        assign ph_sel_q[gi] = (phase_q == PH_W'(gi));
        assign ph_sel_d[gi] = (phase_d == PH_W'(gi));
    end

    assign phase_inc   = (phase_q == LAST_PHASE) ? '0 : phase_q + PH_W'(1);
    assign phase_legal = ({1'b0, phase_q} < (PH_W + 1)'(N_PHASES));

    // Next-state logic: state, timer, phase, served flag, flash toggle, pending requests.
    always_comb begin
        state_d  = state_q;
        phase_d  = phase_q;
        timer_d  = timer_q;
        served_d = served_q;
        toggle_d = toggle_q;
        pend_clr = '0;
        if (!phase_legal) begin
            state_d  = ST_START;
            phase_d  = '0;
            timer_d  = '0;
            served_d = 1'b0;
            toggle_d = 1'b0;
        end else begin
            case (state_q)
                ST_START: begin
                    if (tick) begin
                        state_d = ST_ALLRED;
                        timer_d = ALLRED_LD;
                    end
                end
                ST_ALLRED: begin
                    if (tick) begin
                        if (timer_q == '0) begin
                            if (flash_mode) begin
                                state_d  = ST_FLASH;
                                toggle_d = 1'b0;
                            end else begin
                                state_d = ST_GREEN;
                                if (|(pend_q & ph_sel_q)) begin
                                    timer_d  = GREEN_PED_LD;
                                    served_d = 1'b1;
                                    pend_clr = ph_sel_q;
                                end else begin
                                    timer_d  = GREEN_LD;
                                    served_d = 1'b0;
                                end
                            end
                        end else begin
                            timer_d = timer_q - CNT_W'(1);
                        end
                    end
                end
                ST_GREEN: begin
                    if (tick) begin
                        if (timer_q == '0) begin
                            state_d  = ST_YELLOW;
                            timer_d  = YELLOW_LD;
                            served_d = 1'b0;
                        end else begin
                            timer_d = timer_q - CNT_W'(1);
                        end
                    end
                end
                ST_YELLOW: begin
                    if (tick) begin
                        if (timer_q == '0) begin
                            state_d = ST_ALLRED;
                            timer_d = ALLRED_LD;
                            phase_d = phase_inc;
                        end else begin
                            timer_d = timer_q - CNT_W'(1);
                        end
                    end
                end
                ST_FLASH: begin
                    if (tick) begin
                        if (!flash_mode) begin
                            state_d = ST_ALLRED;
                            timer_d = ALLRED_LD;
                            phase_d = '0;
                        end else begin
                            toggle_d = ~toggle_q;
                        end
                    end
                end
                default: begin
                    state_d  = ST_START;
                    phase_d  = '0;
                    timer_d  = '0;
                    served_d = 1'b0;
                    toggle_d = 1'b0;
                end
            endcase
        end
        // A new request on the same clock as the clear wins.
        pend_d = (pend_q & ~pend_clr) | ped_req;
    end

    // Lamp decode of the next state, registered alongside the state.
    always_comb begin
        r_d    = '0;
        y_d    = '0;
        g_d    = '0;
        walk_d = '0;
        case (state_d)
            ST_ALLRED: r_d = '1;
            ST_GREEN: begin
                g_d    = ph_sel_d;
                r_d    = ~ph_sel_d;
                walk_d = served_d ? ph_sel_d : '0;
            end
            ST_YELLOW: begin
                y_d = ph_sel_d;
                r_d = ~ph_sel_d;
            end
            ST_FLASH: y_d = toggle_d ? '1 : '0;
            default: ;
        endcase
    end

    // State and output registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_START;
            phase_q  <= '0;
            timer_q  <= '0;
            pend_q   <= '0;
            served_q <= 1'b0;
            toggle_q <= 1'b0;
            r_q      <= '0;
            y_q      <= '0;
            g_q      <= '0;
            walk_q   <= '0;
        end else begin
            state_q  <= state_d;
            phase_q  <= phase_d;
            timer_q  <= timer_d;
            pend_q   <= pend_d;
            served_q <= served_d;
            toggle_q <= toggle_d;
            r_q      <= r_d;
            y_q      <= y_d;
            g_q      <= g_d;
            walk_q   <= walk_d;
        end
    end

    assign r     = r_q;
    assign y     = y_q;
    assign g     = g_q;
    assign walk  = walk_q;
    assign phase = phase_q;

endmodule
